mult_datapath: RTL

- Datapath half of the sequential signed shift-add multiplier; it receives the control strobes from the control unit and returns the status flags the control unit needs.
- On `load` it captures two signed operands as magnitudes plus a result sign.
- On `reg_en` / `shift_en` strobes it performs one add-and/or-shift step per cycle.
- It exposes `z_flag_multiplicand` / `lsb_multiplicand` back to the controller, plus the signed product for the display path.

---
 rtl/mult_datapath.sv | 101 ++++++++++
 1 files changed

// File: rtl/mult_datapath.sv
// ---------------------------------------------------------------------------
// mult_datapath
//   Datapath half of a sequential signed shift-add multiplier. Operands are
//   captured as magnitudes plus a result sign. Each controller strobe then
//   performs one add step, one shift step, or both. The signed product is
//   rebuilt combinationally from the unsigned accumulator.
//
// Ports
//   clk                 : system clock, rising edge
//   rst_n               : asynchronous active-low reset
//   a, b                : signed operands (W bits)
//   load                : capture operands and clear the accumulator
//                         (this has priority over all other strobes)
//   reg_en              : accumulator update enable
//   psel                : 1 = add the shifted multiplier, 0 = add zero
//   shift_en            : shift the multiplicand right and the multiplier left
//   z_flag_multiplicand : multiplicand register == 0
//   lsb_multiplicand    : bit 0 of the multiplicand register
//   product             : signed result (2*W bits, two's complement)
//   done                : product valid (loaded and multiplicand exhausted)
// ---------------------------------------------------------------------------
module mult_datapath #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   input  logic           load,
   input  logic           reg_en,
   input  logic           psel,
   input  logic           shift_en,
   output logic           z_flag_multiplicand,
   output logic           lsb_multiplicand,
   output logic [2*W-1:0] product,
   output logic           done
);

   logic [W-1:0]   mcand_q,  mcand_d;
   logic [2*W-1:0] mplier_q, mplier_d;
   logic [2*W-1:0] acc_q,    acc_d;
   logic           sign_q,   sign_d;
   logic           loaded_q, loaded_d;

   logic [W-1:0]   a_mag;
   logic [W-1:0]   b_mag;

   // The most negative value negates to itself, and as an unsigned number
   // that is exactly its magnitude. So no saturation is needed.
   assign a_mag = a[W-1] ? (~a + 1'b1) : a;
   assign b_mag = b[W-1] ? (~b + 1'b1) : b;

   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      sign_d   = sign_q;
      loaded_d = loaded_q;
      if (load) begin
         mcand_d  = a_mag;
         mplier_d = {{W{1'b0}}, b_mag};
         acc_d    = '0;
         sign_d   = a[W-1] ^ b[W-1];
         loaded_d = 1'b1;
      end else begin
         // The add reads the pre-shift multiplier. Both updates commit
         // together when reg_en and shift_en are high in the same cycle.
         if (reg_en) begin
            acc_d = acc_q + (psel ? mplier_q : '0);
         end
         if (shift_en) begin
            mcand_d  = mcand_q >> 1;
            mplier_d = mplier_q << 1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         sign_q   <= 1'b0;
         loaded_q <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         sign_q   <= sign_d;
         loaded_q <= loaded_d;
      end
   end

   assign z_flag_multiplicand = (mcand_q == '0);
   assign lsb_multiplicand    = mcand_q[0];

   // Negating zero gives zero, so a zero accumulator never shows as -0.
   assign product = sign_q ? ('0 - acc_q) : acc_q;
   assign done    = loaded_q & z_flag_multiplicand;

endmodule
